// File: rtl/mips_mul_div_32b.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, MSB first.
module mips_mul_div_32b (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] leftOperand,
  input  logic [31:0] rightOperand,
  input  logic        hiWrite,
  input  logic        loWrite,
  input  logic [31:0] writeData,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [1:0]  op_q;
  logic [31:0] a, b, left_raw;
  logic [63:0] acc;
  logic [32:0] rem;
  logic        neg_res, neg_rem;
  logic [4:0]  cnt;

  logic        lneg, rneg;
  logic [33:0] shifted;
  logic [32:0] rem_next;
  logic [63:0] acc_next, prod;
  logic [31:0] quo, rmd, res_hi, res_lo;

  assign lneg = ~op[0] & leftOperand[31];
  assign rneg = ~op[0] & rightOperand[31];

  // Operands stay put; cnt selects the current bit (31 down to 0), so the
  // multiplier bit and the next dividend bit are both a[cnt]/b[cnt].
  always_comb begin
    shifted  = {rem, a[cnt]};
    rem_next = rem;
    acc_next = {acc[62:0], 1'b0};
    if (op_q[1]) begin
      if (shifted >= {2'b00, b}) begin
        rem_next    = 33'(shifted - {2'b00, b});
        acc_next[0] = 1'b1;
      end else begin
        rem_next = shifted[32:0];
      end
    end else if (b[cnt]) begin
      acc_next = {acc[62:0], 1'b0} + {32'h0, a};
    end
    prod = neg_res ? -acc_next : acc_next;
    quo  = neg_res ? -acc_next[31:0] : acc_next[31:0];
    rmd  = neg_rem ? -rem_next[31:0] : rem_next[31:0];
    if (!op_q[1]) begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end else if (b == '0) begin
      res_hi = left_raw;
      res_lo = '1;
    end else begin
      res_hi = rmd;
      res_lo = quo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= '0;
      a        <= '0;
      b        <= '0;
      left_raw <= '0;
      acc      <= '0;
      rem      <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            op_q     <= op;
            a        <= lneg ? -leftOperand : leftOperand;
            b        <= rneg ? -rightOperand : rightOperand;
            left_raw <= leftOperand;
            neg_res  <= lneg ^ rneg;
            neg_rem  <= lneg;
            acc      <= '0;
            rem      <= '0;
            cnt      <= 5'd31;
            busy     <= 1'b1;
            state    <= RUN;
          end else begin
            if (hiWrite) hi <= writeData;
            if (loWrite) lo <= writeData;
            state <= IDLE;
          end
        end
        RUN: begin
          acc <= acc_next;
          rem <= rem_next;
          if (cnt == 5'd0) begin
            hi    <= res_hi;
            lo    <= res_lo;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mul_div_32b.sv
// Directed self-checking bench for mips_mul_div_32b: products, quotients,
// divide-by-zero, overflow case, handshake corner cases and mid-run reset.
module tb_mips_mul_div_32b;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] leftOperand = '0;
  logic [31:0] rightOperand = '0;
  logic        hiWrite = 1'b0;
  logic        loWrite = 1'b0;
  logic [31:0] writeData = '0;
  logic [31:0] hi, lo;
  logic        busy, done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cyc1, done_cyc2;
  logic [31:0] prev_hi = '0;
  logic [31:0] prev_lo = '0;

  mips_mul_div_32b dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .leftOperand(leftOperand), .rightOperand(rightOperand),
    .hiWrite(hiWrite), .loWrite(loWrite), .writeData(writeData),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts an op at the next negedge; returns just after the edge that raised done.
  task automatic do_op(input logic [1:0] o, input logic [31:0] l, input logic [31:0] r,
                       input logic [31:0] eh, input logic [31:0] el,
                       input logic disturb, input logic lowr, input string tag);
    int n;
    int busy_cnt;
    @(negedge clk);
    start = 1'b1; op = o; leftOperand = l; rightOperand = r;
    if (lowr) begin loWrite = 1'b1; writeData = 32'h5555_5555; end
    @(posedge clk); #1;
    start = 1'b0; loWrite = 1'b0;
    n = 0;
    busy_cnt = 0;
    while (!done && n < 40) begin
      if (busy) busy_cnt++;
      check({tag, "_hold"}, {hi, lo}, {prev_hi, prev_lo});
      if (disturb && n == 5) begin
        start = 1'b1; hiWrite = 1'b1; writeData = 32'hDEAD_BEEF;
        op = ~o; leftOperand = 32'h1234_5678; rightOperand = 32'h0000_0009;
      end else begin
        start = 1'b0; hiWrite = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_done"}, {63'd0, done}, 64'd1);
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd32);
    check({tag, "_busy_low"}, {63'd0, busy}, 64'd0);
    check({tag, "_result"}, {hi, lo}, {eh, el});
    prev_hi = eh;
    prev_lo = el;
  endtask

  task automatic go_idle(input string tag);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, {62'd0, done, busy}, 64'd0);
  endtask

  initial begin
    #12;
    check("reset", {hi, lo, 30'd0, busy, done}, 96'd0);
    @(negedge clk); rst_n = 1'b1;

    do_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0, "mult_m3x7");
    go_idle("mult_m3x7");
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0, "multu_max");
    go_idle("multu_max");
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0, "mult_m1xm1");
    go_idle("mult_m1xm1");
    do_op(2'b00, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, "mult_min_x2");
    go_idle("mult_min_x2");
    do_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0, "div_m7_2");
    go_idle("div_m7_2");
    do_op(2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0, 1'b0, "divu_7_2");
    go_idle("divu_7_2");
    do_op(2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0, 1'b0, "divu_max_16");
    go_idle("divu_max_16");
    do_op(2'b10, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 1'b0, "div_by0");
    go_idle("div_by0");
    do_op(2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0, 1'b0, "div_neg_by0");
    go_idle("div_neg_by0");
    do_op(2'b11, 32'h8000_0001, 32'h0000_0000, 32'h8000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, "divu_by0");
    go_idle("divu_by0");
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0, "div_ovf");
    go_idle("div_ovf");

    // Inputs disturbed mid-run must not affect the result or HI.
    do_op(2'b00, 32'h0000_0006, 32'h0000_0007, 32'h0000_0000, 32'h0000_002A, 1'b1, 1'b0, "mid_run_ignore");
    go_idle("mid_run_ignore");

    // start + mtlo in same idle cycle: start wins, LO not written.
    do_op(2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0, 1'b1, "start_vs_mtlo");
    go_idle("start_vs_mtlo");

    // Back-to-back: second start issued during the DONE cycle.
    do_op(2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, "b2b_first");
    done_cyc1 = cyc;
    do_op(2'b11, 32'h1234_5678, 32'h0000_0100, 32'h0000_0078, 32'h0012_3456, 1'b0, 1'b0, "b2b_second");
    done_cyc2 = cyc;
    check("b2b_spacing", 64'(done_cyc2 - done_cyc1), 64'd33);
    go_idle("b2b_second");

    // mthi / mtlo.
    @(negedge clk); hiWrite = 1'b1; writeData = 32'hCAFE_BABE;
    @(posedge clk); #1; hiWrite = 1'b0;
    check("mthi", {32'd0, hi}, {32'd0, 32'hCAFE_BABE});
    @(negedge clk); loWrite = 1'b1; writeData = 32'h0000_0001;
    @(posedge clk); #1; loWrite = 1'b0;
    check("mtlo", {hi, lo}, {32'hCAFE_BABE, 32'h0000_0001});

    // Reset mid-run aborts with no done.
    @(negedge clk); start = 1'b1; op = 2'b01; leftOperand = 32'h0000_0003; rightOperand = 32'h0000_0005;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #1; rst_n = 1'b0;
    #1;
    check("reset_mid_run", {hi, lo, 30'd0, busy, done}, 96'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_no_done", {62'd0, busy, done}, 64'd0);
    end
    rst_n = 1'b1;
    prev_hi = '0;
    prev_lo = '0;
    do_op(2'b01, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F, 1'b0, 1'b0, "multu_after_reset");
    go_idle("multu_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: observed=no_finish expected=finish");
    $fatal(1, "timeout");
  end

endmodule
